// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline definitions.
// Fetch FSM states, NOP encoding and data width.
package riscv_pkg;

   localparam int XLEN = 32;

   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT,
      DROP,
      HOLD
   } fetch_state_t;

endpackage

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register.
// Flush beats stall; an idle cycle loads a bubble.
import riscv_pkg::*;

module ifid_reg (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            en,
   input  logic            flush,
   input  logic            load,
   input  logic [XLEN-1:0] Instr,
   input  logic [XLEN-1:0] Pc,
   input  logic [XLEN-1:0] PcPlus4,
   output logic [XLEN-1:0] InstrD,
   output logic [XLEN-1:0] PCD,
   output logic [XLEN-1:0] PCPlus4D,
   output logic            ValidD
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         InstrD   <= NOP_INSTR;
         PCD      <= '0;
         PCPlus4D <= '0;
         ValidD   <= 1'b0;
      end else if (flush) begin
         InstrD   <= NOP_INSTR;
         PCD      <= '0;
         PCPlus4D <= '0;
         ValidD   <= 1'b0;
      end else if (en) begin
         if (load) begin
            InstrD   <= Instr;
            PCD      <= Pc;
            PCPlus4D <= PcPlus4;
            ValidD   <= 1'b1;
         end else begin
            InstrD   <= NOP_INSTR;
            PCD      <= '0;
            PCPlus4D <= '0;
            ValidD   <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, single-outstanding imem handshake,
// hold buffer for stalled responses, and the IF/ID register.
import riscv_pkg::*;

module fetch_stage #(
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            StallF,
   input  logic            StallD,
   input  logic            FlushD,
   input  logic            PcSrcE,
   input  logic [XLEN-1:0] PcTargetE,
   output logic            ImemReq,
   output logic [XLEN-1:0] ImemAddr,
   input  logic            ImemReady,
   input  logic            ImemRvalid,
   input  logic [XLEN-1:0] ImemRdata,
   output logic [XLEN-1:0] InstrD,
   output logic [XLEN-1:0] PCD,
   output logic [XLEN-1:0] PCPlus4D,
   output logic            ValidD
);

   fetch_state_t    state, stateNext;
   logic [XLEN-1:0] pcF, pcNext, pcPlus4F;
   logic [XLEN-1:0] holdBuf, holdNext;
   logic [XLEN-1:0] target, loadInstr;
   logic            xferOk, load;

   assign pcPlus4F = pcF + 32'd4;
   assign target   = PcTargetE & ~32'h3;
   assign xferOk   = !StallF && !StallD && !FlushD && !PcSrcE;

   assign ImemReq  = (state == REQ);
   assign ImemAddr = pcF;

   always_comb begin
      stateNext = state;
      pcNext    = pcF;
      holdNext  = holdBuf;
      load      = 1'b0;
      loadInstr = ImemRdata;
      unique case (state)
         IDLE: stateNext = REQ;
         REQ: begin
            if (PcSrcE) begin
               pcNext    = target;
               stateNext = ImemReady ? DROP : REQ;
            end else if (ImemReady) begin
               stateNext = WAIT;
            end
         end
         WAIT: begin
            if (PcSrcE) begin
               pcNext    = target;
               stateNext = ImemRvalid ? REQ : DROP;
            end else if (ImemRvalid) begin
               if (xferOk) begin
                  load      = 1'b1;
                  pcNext    = pcPlus4F;
                  stateNext = REQ;
               end else begin
                  holdNext  = ImemRdata;
                  stateNext = HOLD;
               end
            end
         end
         HOLD: begin
            loadInstr = holdBuf;
            if (PcSrcE) begin
               pcNext    = target;
               stateNext = REQ;
            end else if (xferOk) begin
               load      = 1'b1;
               pcNext    = pcPlus4F;
               stateNext = REQ;
            end
         end
         DROP: begin
            // Redirects here only move the PC; the stale beat must still drain.
            if (PcSrcE) pcNext = target;
            if (ImemRvalid) stateNext = REQ;
         end
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         pcF     <= RESET_PC;
         holdBuf <= NOP_INSTR;
      end else begin
         state   <= stateNext;
         pcF     <= pcNext;
         holdBuf <= holdNext;
      end
   end

   ifid_reg uIfid (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (!StallD),
      .flush    (FlushD),
      .load     (load),
      .Instr    (loadInstr),
      .Pc       (pcF),
      .PcPlus4  (pcPlus4F),
      .InstrD   (InstrD),
      .PCD      (PCD),
      .PCPlus4D (PCPlus4D),
      .ValidD   (ValidD)
   );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a variable-latency
// instruction memory returning addr ^ 0xA5A5_0000.
module tb_fetch_stage;

   localparam logic [31:0] NOP  = 32'h0000_0013;
   localparam logic [31:0] MASK = 32'hA5A5_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        StallF, StallD, FlushD, PcSrcE;
   logic [31:0] PcTargetE;
   logic        ImemReq;
   logic [31:0] ImemAddr;
   logic        ImemReady;
   logic        ImemRvalid;
   logic [31:0] ImemRdata;
   logic [31:0] InstrD, PCD, PCPlus4D;
   logic        ValidD;

   int total = 0;
   int bad   = 0;
   int lat   = 1;

   logic        pend;
   int          cnt;
   logic [31:0] paddr;

   always #5 clk = ~clk;

   fetch_stage #(.RESET_PC(32'h0000_0100)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .StallF     (StallF),
      .StallD     (StallD),
      .FlushD     (FlushD),
      .PcSrcE     (PcSrcE),
      .PcTargetE  (PcTargetE),
      .ImemReq    (ImemReq),
      .ImemAddr   (ImemAddr),
      .ImemReady  (ImemReady),
      .ImemRvalid (ImemRvalid),
      .ImemRdata  (ImemRdata),
      .InstrD     (InstrD),
      .PCD        (PCD),
      .PCPlus4D   (PCPlus4D),
      .ValidD     (ValidD)
   );

   // Memory model: response lat cycles after acceptance.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend       <= 1'b0;
         cnt        <= 0;
         paddr      <= '0;
         ImemRvalid <= 1'b0;
         ImemRdata  <= '0;
      end else begin
         ImemRvalid <= 1'b0;
         if (pend) begin
            if (cnt <= 1) begin
               ImemRvalid <= 1'b1;
               ImemRdata  <= paddr ^ MASK;
               pend       <= 1'b0;
            end else begin
               cnt <= cnt - 1;
            end
         end else if (ImemReq && ImemReady) begin
            if (lat <= 1) begin
               ImemRvalid <= 1'b1;
               ImemRdata  <= ImemAddr ^ MASK;
            end else begin
               pend  <= 1'b1;
               cnt   <= lat - 1;
               paddr <= ImemAddr;
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chkD(input string tag, input logic v,
                       input logic [31:0] ins, input logic [31:0] pc);
      chk({tag, ".valid"}, {31'd0, ValidD}, {31'd0, v});
      chk({tag, ".instr"}, InstrD, ins);
      chk({tag, ".pcd"}, PCD, pc);
   endtask

   task automatic chkF(input string tag, input logic req,
                       input logic [31:0] addr);
      chk({tag, ".req"}, {31'd0, ImemReq}, {31'd0, req});
      chk({tag, ".addr"}, ImemAddr, addr);
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b1;
      StallF = 0; StallD = 0; FlushD = 0; PcSrcE = 0;
      PcTargetE = '0;
      ImemReady = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      chkF("rst", 1'b0, 32'h100);
      chkD("rst", 1'b0, NOP, 32'h0);
      chk("rst.pc4", PCPlus4D, 32'h0);

      step(); step();
      rst_n = 1'b1;
      step();
      chkF("first", 1'b1, 32'h100);
      chkD("first", 1'b0, NOP, 32'h0);
      step();
      chkF("wait0", 1'b0, 32'h100);
      step();
      chkD("seq0", 1'b1, 32'hA5A5_0100, 32'h100);
      chk("seq0.pc4", PCPlus4D, 32'h104);
      chkF("seq0", 1'b1, 32'h104);
      step();
      chkD("seq0b", 1'b0, NOP, 32'h0);
      step();
      chkD("seq1", 1'b1, 32'hA5A5_0104, 32'h104);
      step();
      chkD("seq1b", 1'b0, NOP, 32'h0);
      step();
      chkD("seq2", 1'b1, 32'hA5A5_0108, 32'h108);

      StallF = 1; StallD = 1;
      step();
      chkD("stall0", 1'b1, 32'hA5A5_0108, 32'h108);
      step();
      chkD("stall1", 1'b1, 32'hA5A5_0108, 32'h108);
      chk("stall1.req", {31'd0, ImemReq}, 32'd0);
      step();
      chkD("stall2", 1'b1, 32'hA5A5_0108, 32'h108);
      StallF = 0; StallD = 0;
      step();
      chkD("hold", 1'b1, 32'hA5A5_010C, 32'h10C);
      chkF("hold", 1'b1, 32'h110);
      step();
      chkD("holdb", 1'b0, NOP, 32'h0);
      step();
      chkD("after", 1'b1, 32'hA5A5_0110, 32'h110);

      lat = 3;
      step();
      PcSrcE = 1; PcTargetE = 32'h0000_0203;
      step();
      PcSrcE = 0; PcTargetE = '0;
      chkF("drop0", 1'b0, 32'h200);
      chkD("drop0", 1'b0, NOP, 32'h0);
      step();
      lat = 1;
      chkF("drop1", 1'b0, 32'h200);
      chk("drop1.rv", {31'd0, ImemRvalid}, 32'd1);
      step();
      chkF("redir", 1'b1, 32'h200);
      chkD("redir", 1'b0, NOP, 32'h0);
      step();
      chk("same.rv", {31'd0, ImemRvalid}, 32'd1);
      PcSrcE = 1; PcTargetE = 32'h0000_0300; FlushD = 1;
      step();
      PcSrcE = 0; PcTargetE = '0; FlushD = 0;
      chkF("same", 1'b1, 32'h300);
      chkD("same", 1'b0, NOP, 32'h0);

      ImemReady = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         chkF($sformatf("nrdy%0d", i), 1'b1, 32'h300);
         chkD($sformatf("nrdy%0d", i), 1'b0, NOP, 32'h0);
      end
      ImemReady = 1'b1;
      step();
      step();
      chkD("rdy", 1'b1, 32'hA5A5_0300, 32'h300);
      chkF("rdy", 1'b1, 32'h304);

      PcSrcE = 1; PcTargetE = 32'hFFFF_FFFC;
      step();
      PcSrcE = 0; PcTargetE = '0;
      chkF("wrapdrop", 1'b0, 32'hFFFF_FFFC);
      step();
      chkF("wrapreq", 1'b1, 32'hFFFF_FFFC);
      chkD("wrapreq", 1'b0, NOP, 32'h0);
      step();
      step();
      chkD("wrap", 1'b1, 32'h5A5A_FFFC, 32'hFFFF_FFFC);
      chk("wrap.pc4", PCPlus4D, 32'h0);
      chkF("wrap", 1'b1, 32'h0);
      step();
      chkF("midwait", 1'b0, 32'h0);
      rst_n = 1'b0;
      #1;
      chkF("rst2", 1'b0, 32'h100);
      chkD("rst2", 1'b0, NOP, 32'h0);
      chk("rst2.pc4", PCPlus4D, 32'h0);
      step();
      rst_n = 1'b1;
      step();
      chkF("restart", 1'b1, 32'h100);
      step();
      step();
      chkD("restart", 1'b1, 32'hA5A5_0100, 32'h100);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register of the 5-stage RV32I pipeline. It holds the PC (PCF) and fetches from instruction memory over a single-outstanding request/response handshake. It delivers {InstrD, PCD, PCPlus4D, ValidD} to decode. It obeys StallF/StallD/FlushD and the execute-stage redirect (PcSrcE/PcTargetE) produced by the hazard unit and branch logic, discarding wrong-path responses in flight.

## Interface
- RESET_PC, 32'h0000_0000, PC fetched first after reset
- XLEN, 32, address/data width; only 32 supported
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- StallF  in  1  hold PCF; no transfer into decode
- StallD  in  1  hold IF/ID contents
- FlushD  in  1  load bubble into IF/ID
- PcSrcE  in  1  redirect taken in execute
- PcTargetE  in  32  redirect target
- ImemReq  out  1  request valid
- ImemAddr  out  32  request address (= PCF)
- ImemReady  in  1  memory accepts request this cycle
- ImemRvalid  in  1  response valid
- ImemRdata  in  32  instruction word
- InstrD  out  32  instruction to decode
- PCD  out  32  PC of InstrD
- PCPlus4D  out  32  PCD + 4
- ValidD  out  1  InstrD is a real instruction (0 = bubble)

## Operation
- States: IDLE, REQ, WAIT, DROP, HOLD. Reset -> IDLE; IDLE -> REQ unconditionally.
- REQ: ImemReq=1, ImemAddr=PCF. If ImemReq & ImemReady -> WAIT; else stay.
- WAIT: await ImemRvalid. On response: if transfer allowed -> write IF/ID, PCF<=PCF+4, -> REQ; else latch ImemRdata into hold buffer -> HOLD.
- HOLD: buffered word transfers when allowed, then PCF<=PCF+4, -> REQ.
- Transfer allowed = !StallF & !StallD & !FlushD & !PcSrcE.
- DROP: await ImemRvalid; discard data; -> REQ. ImemReq=0.
- Redirect (PcSrcE=1), highest priority: PCF<=PcTargetE. From REQ with handshake accepted this cycle -> DROP. From REQ without handshake -> REQ. From WAIT without ImemRvalid this cycle -> DROP. From WAIT with ImemRvalid, or from HOLD -> REQ, data discarded. From DROP -> DROP, target still updated.
- IF/ID register, priority order:
  - FlushD -> InstrD=32'h0000_0013 (NOP), ValidD=0, PCD/PCPlus4D=0.
  - Else StallD -> hold all.
  - Else transfer -> load word, PCF, PCF+4, ValidD=1.
  - Else -> bubble (NOP, ValidD=0).
- PCF+4 wraps modulo 2^32. PcTargetE[1:0] are ignored (forced 0).

## Timing
- Reset values: PCF=RESET_PC, state IDLE, ImemReq=0, ImemAddr=RESET_PC, InstrD=NOP, PCD=0, PCPlus4D=0, ValidD=0. Async assert; outputs reach reset values without a clock.
- First ImemReq=1 in the first cycle after rst_n deassert + 1 edge (IDLE->REQ).
- Data seen with ImemRvalid in cycle N appears on InstrD in cycle N+1.
- Peak throughput is 1 instruction per 2 cycles with 1-cycle memory; at most one request outstanding.
- ImemReq/ImemAddr are pure functions of registered state (no combinational path from Imem inputs or hazard inputs).
- Redirect latency: ImemAddr=PcTargetE in the cycle after PcSrcE, unless in DROP.
- ImemRvalid outside WAIT/DROP is ignored.
- rst_n asserted mid-transaction: the outstanding response is lost, and memory must also be reset.

## Structure
- riscv_pkg: NOP_INSTR constant, fetch_state_t enum, XLEN.
- One sub-module, ifid_reg: IF/ID register with enable (!StallD), flush, and bubble load.
- FSM, PCF, and hold buffer in fetch_stage.

## Test plan
- Reset, RESET_PC=0x100, 1-cycle memory returning addr^0xA5A5_0000 -> InstrD sequence 0xA5A5_0100, 0x..0104, 0x..0108, ValidD=1 every other cycle.
- StallF=StallD=1 for 3 cycles while response arrives -> HOLD; InstrD unchanged; after release the buffered word appears once with PCD correct, no duplicate or skip.
- PcSrcE=1, PcTargetE=0x200 while in WAIT (response 3 cycles later) -> DROP; stale word never reaches InstrD; next ImemAddr=0x200.
- PcSrcE and ImemRvalid in the same cycle -> word discarded, FlushD gives ValidD=0, ImemAddr=target next cycle.
- ImemReady held low 5 cycles -> ImemReq stays 1 with stable ImemAddr; decode sees bubbles (NOP, ValidD=0).
- PCF=0xFFFF_FFFC fetch -> PCPlus4D=0, next ImemAddr=0; rst_n pulsed mid-WAIT -> immediate reset values, fetch restarts at RESET_PC.
